bcd_display_sequencer: RTL and testbench
========================================

# bcd_display_sequencer

Sequential binary-to-decimal display controller for the board 7-segment digits. Accepts an unsigned binary value over a valid/ready handshake, converts it to three BCD digits with an iterative shift-add-3 (double-dabble) datapath, one bit per clock, then updates the hundreds/tens/ones displays atomically. It sits between switch/counter logic and the HEX outputs, replacing per-value combinational comparator/correction logic with a single reusable sequenced converter.

## Interface
- WIDTH, 8, input value width; legal range 4..8 (max 255 fits three digits)
- Clock  in  1  rising-edge system clock
- Resetn  in  1  asynchronous, active-low reset
- value  in  WIDTH  unsigned binary value to display
- in_valid  in  1  value is presented
- in_ready  out  1  block can accept; high only in IDLE
- blank_lz  in  1  blank leading zeros on HEX2/HEX1 (combinational, applied to held digits)
- busy  out  1  conversion in progress (CONV or UPDATE)
- done  out  1  one-cycle pulse: displays just updated
- HEX2  out  7  hundreds digit, active-low segments, bit0=a .. bit6=g
- HEX1  out  7  tens digit, same encoding
- HEX0  out  7  ones digit, same encoding

## Operation
- States: IDLE, CONV, UPDATE.
- IDLE: in_ready=1. On in_valid&in_ready: shift reg <= value, work BCD (12 bits) <= 0, cnt <= WIDTH, go CONV.
- CONV: per cycle, for each working digit ≥5 add 3 (4-bit, no carry out), then shift {bcd, shreg} left one bit; cnt decrements. When cnt reaches 1 before the step, next state UPDATE.
- UPDATE: display digit regs <= working BCD; done <= 1 for one cycle; go IDLE.
- Display digits held until next UPDATE; value changes after acceptance have no effect.
- in_valid while busy ignored (no queueing).
- Segment map (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10..15 and blank = 1111111.
- blank_lz=1: HEX2 blank if hundreds=0; HEX1 blank if hundreds=0 and tens=0; HEX0 never blanked.

## Timing
- Reset (asynchronous, any state): state=IDLE, digit regs=0, done=0, busy=0, in_ready=1; HEX0=1000000, HEX1/HEX2=1000000 (or 1111111 when blank_lz=1).
- Accept at edge E0 → CONV for edges E1..E_WIDTH → UPDATE; HEX and done change at E_(WIDTH+1).
- Latency accept→display: WIDTH+1 cycles; next accept earliest at E_(WIDTH+2); throughput one value per WIDTH+2 cycles.
- busy high from after E0 through E_(WIDTH+1); in_ready = ~busy.
- Reset mid-CONV/UPDATE: conversion discarded, no done, displays return to reset value.
- blank_lz toggle takes effect combinationally; does not restart conversion.

## Structure
- Package bcd_disp_pkg: state enum, SEG_BLANK=7'h7F, 10-entry digit segment constants, DIGIT_W=4.
- One sub-module: seg7_decode (4-bit digit + blank in → 7-bit active-low segments), instantiated three times.
- Datapath (add-3 correction, shift, counter) and FSM live in the top module.

## Test plan
- Reset with no input → HEX2/1/0 = 1000000 each, in_ready=1, busy=0, done=0; with blank_lz=1 HEX2/HEX1=1111111.
- Accept 255 (WIDTH=8) → done at cycle 9 after accept, HEX2=0100100, HEX1=0010010, HEX0=0010010.
- Accept 7, blank_lz=1 → HEX2=HEX1=1111111, HEX0=1111000; toggle blank_lz=0 → HEX2=HEX1=1000000, no done.
- Hold in_valid high with changing value across a conversion → only first value displayed, next accepted exactly at E_(WIDTH+2).
- Assert Resetn low at CONV cycle 4 of value 200 → no done, displays 0, in_ready=1 immediately; next value 19 converts to 0/1/9.
- Exhaustive sweep 0..2^WIDTH-1 for WIDTH=8 and WIDTH=4 (15 → 0/1/5, latency 5) against a decimal reference model.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD display sequencer.
package bcd_disp_pkg;

   localparam int DIGIT_W = 4;

   // Active-low segments, bit0=a .. bit6=g
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'b1000000,   // 0
      7'b1111001,   // 1
      7'b0100100,   // 2
      7'b0110000,   // 3
      7'b0011001,   // 4
      7'b0010010,   // 5
      7'b0000010,   // 6
      7'b1111000,   // 7
      7'b0000000,   // 8
      7'b0010000    // 9
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV   = 2'd1,
      ST_UPDATE = 2'd2
   } state_e;

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-low 7-segment pattern; non-decimal codes and
// the blank request both produce an unlit digit.
module seg7_decode
   import bcd_disp_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   input  logic               blank_i,
   output logic [6:0]         seg_o
);

   // Table lookup, blank wins over the digit value
   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         case (digit_i)
            4'd0:    seg_o = SEG_DIGIT[0];
            4'd1:    seg_o = SEG_DIGIT[1];
            4'd2:    seg_o = SEG_DIGIT[2];
            4'd3:    seg_o = SEG_DIGIT[3];
            4'd4:    seg_o = SEG_DIGIT[4];
            4'd5:    seg_o = SEG_DIGIT[5];
            4'd6:    seg_o = SEG_DIGIT[6];
            4'd7:    seg_o = SEG_DIGIT[7];
            4'd8:    seg_o = SEG_DIGIT[8];
            4'd9:    seg_o = SEG_DIGIT[9];
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/bcd_display_sequencer.sv
// Sequential binary-to-BCD display controller: accepts a value, runs one
// double-dabble step per clock, then updates all three digits at once.
//
//  state     | meaning
//  ----------+--------------------------------------------------------
//  ST_IDLE   | ready for a new value (in_ready=1)
//  ST_CONV   | one add-3/shift step per cycle, cnt counts bits left
//  ST_UPDATE | copy working BCD to display regs, pulse done
module bcd_display_sequencer
   import bcd_disp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic [WIDTH-1:0] value,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             blank_lz,
   output logic             busy,
   output logic             done,
   output logic [6:0]       HEX2,
   output logic [6:0]       HEX1,
   output logic [6:0]       HEX0
);

   localparam int BCD_W = 3 * DIGIT_W;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e             state_q;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0]   cnt_q;
   logic [BCD_W-1:0]   dig_q;
   logic               done_q;
   logic               blank_hund, blank_tens;

   // Add-3 correction on every working digit, then shift {bcd, shreg} left;
   // the carry out of the top digit is dropped since 255 fits three digits
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[DIGIT_W*i +: DIGIT_W] >= 4'd5)
            bcd_adj[DIGIT_W*i +: DIGIT_W] = bcd_q[DIGIT_W*i +: DIGIT_W] + 4'd3;
      end
      {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
   end

   // Sequencer FSM with the conversion datapath and held display digits
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         dig_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  shreg_q <= value;
                  bcd_q   <= '0;
                  cnt_q   <= CNT_INIT;
                  state_q <= ST_CONV;
               end
            end
            ST_CONV: begin
               shreg_q <= shreg_d;
               bcd_q   <= bcd_d;
               cnt_q   <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE)
                  state_q <= ST_UPDATE;
            end
            ST_UPDATE: begin
               dig_q   <= bcd_q;
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready = (state_q == ST_IDLE);
   assign busy     = ~in_ready;
   assign done     = done_q;

   // Leading-zero blanking looks at the held digits, so it can toggle freely
   assign blank_hund = blank_lz && (dig_q[11:8] == 4'd0);
   assign blank_tens = blank_hund && (dig_q[7:4] == 4'd0);

   seg7_decode u_seg_hund (.digit_i(dig_q[11:8]), .blank_i(blank_hund), .seg_o(HEX2));
   seg7_decode u_seg_tens (.digit_i(dig_q[7:4]),  .blank_i(blank_tens), .seg_o(HEX1));
   seg7_decode u_seg_ones (.digit_i(dig_q[3:0]),  .blank_i(1'b0),       .seg_o(HEX0));

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Bench for bcd_display_sequencer: WIDTH=8 and WIDTH=4 instances compared
// against a decimal-arithmetic display model.
module tb_bcd_display_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       blank_lz;
   logic       vld;
   logic       sel4;
   logic [7:0] value8;
   logic [3:0] value4;
   logic       in_valid8, in_valid4;
   logic       in_ready8, in_ready4, busy8, busy4, done8, done4;
   logic [6:0] hex2_8, hex1_8, hex0_8, hex2_4, hex1_4, hex0_4;

   logic       in_ready_m, busy_m, done_m;
   logic [6:0] hex2_m, hex1_m, hex0_m;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   assign in_valid8 = vld && !sel4;
   assign in_valid4 = vld && sel4;
   assign in_ready_m = sel4 ? in_ready4 : in_ready8;
   assign busy_m     = sel4 ? busy4 : busy8;
   assign done_m     = sel4 ? done4 : done8;
   assign hex2_m     = sel4 ? hex2_4 : hex2_8;
   assign hex1_m     = sel4 ? hex1_4 : hex1_8;
   assign hex0_m     = sel4 ? hex0_4 : hex0_8;

   bcd_display_sequencer #(.WIDTH(8)) u_dut8 (
      .Clock(clk), .Resetn(rst_n), .value(value8), .in_valid(in_valid8),
      .in_ready(in_ready8), .blank_lz(blank_lz), .busy(busy8), .done(done8),
      .HEX2(hex2_8), .HEX1(hex1_8), .HEX0(hex0_8)
   );

   bcd_display_sequencer #(.WIDTH(4)) u_dut4 (
      .Clock(clk), .Resetn(rst_n), .value(value4), .in_valid(in_valid4),
      .in_ready(in_ready4), .blank_lz(blank_lz), .busy(busy4), .done(done4),
      .HEX2(hex2_4), .HEX1(hex1_4), .HEX0(hex0_4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [6:0] seg_ref(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Expected segment pattern at display position pos (2=hundreds) for value v
   function automatic logic [6:0] exp_hex(input int v, input bit bl, input int pos);
      int h, t, o;
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      case (pos)
         2:       return (bl && h == 0) ? 7'h7F : seg_ref(h);
         1:       return (bl && h == 0 && t == 0) ? 7'h7F : seg_ref(t);
         default: return seg_ref(o);
      endcase
   endfunction

   task automatic check_display(input string tag, input int v, input bit bl);
      chk({tag, "_hex2"}, hex2_m, exp_hex(v, bl, 2));
      chk({tag, "_hex1"}, hex1_m, exp_hex(v, bl, 1));
      chk({tag, "_hex0"}, hex0_m, exp_hex(v, bl, 0));
   endtask

   // One complete handshake + conversion on the selected instance
   task automatic convert(input bit w4, input int v, input bit bl);
      int lat;
      int w;
      logic [31:0] vv;
      w  = w4 ? 4 : 8;
      vv = v;
      sel4     = w4;
      blank_lz = bl;
      for (int i = 0; i < 40 && !in_ready_m; i++) begin
         @(posedge clk); #1;
      end
      if (!in_ready_m) chk("ready_timeout", in_ready_m, 1'b1);
      value8 = vv[7:0];
      value4 = vv[3:0];
      vld    = 1'b1;
      @(posedge clk); #1;
      vld = 1'b0;
      chk("busy_after_accept", busy_m, 1'b1);
      lat = 0;
      while (!done_m && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, w + 1);
      check_display("conv", v, bl);
      chk("ready_after_done", in_ready_m, 1'b1);
      @(posedge clk); #1;
      chk("done_one_cycle", done_m, 1'b0);
   endtask

   initial begin
      int a, b;
      bit saw_done;

      rst_n    = 1'b0;
      blank_lz = 1'b0;
      vld      = 1'b0;
      sel4     = 1'b0;
      value8   = '0;
      value4   = '0;

      // Reset state
      #12;
      chk("rst_hex2", hex2_8, 7'b1000000);
      chk("rst_hex1", hex1_8, 7'b1000000);
      chk("rst_hex0", hex0_8, 7'b1000000);
      chk("rst_ready", in_ready8, 1'b1);
      chk("rst_busy", busy8, 1'b0);
      chk("rst_done", done8, 1'b0);
      chk("rst_ready4", in_ready4, 1'b1);
      blank_lz = 1'b1;
      #1;
      chk("rst_bl_hex2", hex2_8, 7'h7F);
      chk("rst_bl_hex1", hex1_8, 7'h7F);
      chk("rst_bl_hex0", hex0_8, 7'b1000000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Max value
      convert(1'b0, 255, 1'b0);

      // Leading-zero blanking and live toggle
      convert(1'b0, 7, 1'b1);
      blank_lz = 1'b0;
      #1;
      check_display("toggle", 7, 1'b0);
      chk("toggle_no_done", done8, 1'b0);
      @(posedge clk); #1;
      chk("toggle_no_done2", done8, 1'b0);

      // in_valid held high with changing value: only the accepted value shows
      sel4 = 1'b0;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      value8 = 8'(a);
      vld    = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= 8; k++) begin
         value8 = 8'($urandom_range(0, 255));
         @(posedge clk); #1;
      end
      value8 = 8'(b);
      @(posedge clk); #1;
      chk("hold_done_a", done8, 1'b1);
      check_display("hold_a", a, 1'b0);
      chk("hold_ready_e9", in_ready8, 1'b1);
      @(posedge clk); #1;
      chk("hold_accept_e10", busy8, 1'b1);
      chk("hold_nodone_e10", done8, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         value8 = 8'($urandom_range(0, 255));
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      vld = 1'b0;
      chk("hold_done_b", done8, 1'b1);
      check_display("hold_b", b, 1'b0);
      @(posedge clk); #1;

      // Reset in the middle of a conversion
      value8 = 8'd200;
      vld    = 1'b1;
      @(posedge clk); #1;
      vld = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", in_ready8, 1'b1);
      chk("mid_rst_busy", busy8, 1'b0);
      chk("mid_rst_done", done8, 1'b0);
      check_display("mid_rst", 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done8) saw_done = 1'b1;
      end
      chk("mid_rst_no_done", saw_done, 1'b0);
      check_display("mid_rst_hold", 0, 1'b0);
      convert(1'b0, 19, 1'b0);

      // Narrow instance boundary
      convert(1'b1, 15, 1'b0);

      // Sweeps with random blanking
      for (int v = 0; v < 256; v++) convert(1'b0, v, 1'($urandom_range(0, 1)));
      for (int v = 0; v < 16; v++)  convert(1'b1, v, 1'($urandom_range(0, 1)));

      // Random values, random instance
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1) convert(1'b1, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
         else                           convert(1'b0, $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
